// File: rtl/contrast_level_arbiter.sv
// contrast_level_arbiter
//
// Owns the contrast PWM on-time register and arbitrates three requesters
// (host write > debounced buttons > automatic ramp). Host writes slew toward
// the latched target in bounded steps. Button and ramp requests apply timed,
// clamped steps. Every real change of pwm_on_time is flagged by a one-cycle
// strobe together with its source.
//
// Handshake: host_req is a level held by the host with host_value stable
// until host_ack pulses for exactly one cycle (state DONE). The host must then
// drop host_req. DONE ignores every request, so a request is accepted again
// no earlier than one cycle after the ack.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   host_req/host_value   host write request and requested on-time
//   host_ack              one-cycle pulse when the host target is reached
//   btn_up/btn_down       debounced button levels (exactly one = request)
//   auto_en               enables the automatic ramp
//   pwm_on_time           current on-time to the PWM generator
//   pwm_on_value_changed  one-cycle pulse when pwm_on_time changes
//   change_src            source of last change: 0 none, 1 host, 2 btn, 3 auto
//   active_src            current owner, same encoding (0 in IDLE/DONE)
module contrast_level_arbiter #(
    parameter int    CLOCK_FREQUENCY  = 16000000,
    parameter int    PWM_REG_WIDTH    = 10,
    parameter int    PWM_CYCLE        = 1023,
    parameter int    STEP_VALUE       = 11,
    parameter int    STEP_TIME_MS     = 50,
    parameter int    SLEW_STEP        = 32,
    parameter int    SLEW_TICK_CYCLES = 1600,
    parameter string AUTO_WRAP        = "TRUE",
    parameter int    RESET_VALUE      = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     host_req,
    input  logic [PWM_REG_WIDTH-1:0] host_value,
    output logic                     host_ack,
    input  logic                     btn_up,
    input  logic                     btn_down,
    input  logic                     auto_en,
    output logic [PWM_REG_WIDTH-1:0] pwm_on_time,
    output logic                     pwm_on_value_changed,
    output logic [1:0]               change_src,
    output logic [1:0]               active_src
);

    localparam int W  = PWM_REG_WIDTH;
    localparam int EW = PWM_REG_WIDTH + 1;

    localparam longint STEP_CYCLES = longint'(CLOCK_FREQUENCY) * longint'(STEP_TIME_MS) / 1000;
    localparam logic [24:0] STEP_LAST = 25'(STEP_CYCLES - 1);

    localparam int SLEW_W = (SLEW_TICK_CYCLES > 1) ? $clog2(SLEW_TICK_CYCLES) : 1;
    localparam logic [SLEW_W-1:0] SLEW_LAST = SLEW_W'(SLEW_TICK_CYCLES - 1);

    localparam logic [W-1:0]  CYCLE_W = W'(PWM_CYCLE);
    localparam logic [EW-1:0] CYCLE_X = EW'(PWM_CYCLE);
    localparam logic [W-1:0]  STEP_W  = W'(STEP_VALUE);
    localparam logic [EW-1:0] STEP_X  = EW'(STEP_VALUE);
    localparam logic [W-1:0]  SLEW_SW = W'(SLEW_STEP);
    localparam logic [EW-1:0] SLEW_X  = EW'(SLEW_STEP);
    localparam logic [W-1:0]  RESET_W = W'(RESET_VALUE);
    localparam bit            WRAP    = (AUTO_WRAP == "TRUE");

    localparam logic [1:0] SRC_NONE = 2'd0;
    localparam logic [1:0] SRC_HOST = 2'd1;
    localparam logic [1:0] SRC_BTN  = 2'd2;
    localparam logic [1:0] SRC_AUTO = 2'd3;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HOST_SLEW = 3'd1,
        BTN_STEP  = 3'd2,
        AUTO_STEP = 3'd3,
        DONE      = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [W-1:0]        pwm_q, pwm_d;
    logic [W-1:0]        target_q, target_d;
    logic [24:0]         step_cnt_q, step_cnt_d;
    logic [SLEW_W-1:0]   slew_cnt_q, slew_cnt_d;
    logic                host_ack_q, host_ack_d;
    logic                changed_q, changed_d;
    logic [1:0]          change_src_q, change_src_d;

    // Candidate next values, all derived from the current register value.
    logic          btn_valid;
    logic          step_tick;
    logic          slew_tick;
    logic [EW-1:0] pwm_x;
    logic [EW-1:0] up_sum;
    logic [W-1:0]  up_val;
    logic [W-1:0]  down_val;
    logic [W-1:0]  btn_val;
    logic [W-1:0]  auto_val;
    logic [W-1:0]  host_tgt;
    logic [W-1:0]  slew_dist;
    logic [W-1:0]  slew_amt;
    logic [W-1:0]  slew_val;
    logic [1:0]    upd_src;

    always_comb begin
        btn_valid = btn_up ^ btn_down;
        step_tick = (step_cnt_q == STEP_LAST);
        slew_tick = (slew_cnt_q == SLEW_LAST);

        // The sum is one bit wider so the carry is seen before clamping.
        pwm_x  = {1'b0, pwm_q};
        up_sum = pwm_x + STEP_X;
        up_val = (up_sum > CYCLE_X) ? CYCLE_W : up_sum[W-1:0];
        down_val = (pwm_q >= STEP_W) ? (pwm_q - STEP_W) : '0;
        btn_val  = btn_up ? up_val : down_val;
        auto_val = (up_sum > CYCLE_X) ? (WRAP ? '0 : CYCLE_W) : up_sum[W-1:0];

        host_tgt = ({1'b0, host_value} > CYCLE_X) ? CYCLE_W : host_value;

        // Slew moves by at most SLEW_STEP but never past the target.
        slew_dist = (target_q > pwm_q) ? (target_q - pwm_q) : (pwm_q - target_q);
        slew_amt  = ({1'b0, slew_dist} > SLEW_X) ? SLEW_SW : slew_dist;
        slew_val  = (target_q > pwm_q) ? (pwm_q + slew_amt) : (pwm_q - slew_amt);
    end

    always_comb begin
        state_d    = state_q;
        pwm_d      = pwm_q;
        target_d   = target_q;
        step_cnt_d = step_cnt_q;
        slew_cnt_d = slew_cnt_q;
        host_ack_d = 1'b0;
        upd_src    = SRC_NONE;

        case (state_q)
            IDLE: begin
                if (host_req) begin
                    state_d    = HOST_SLEW;
                    target_d   = host_tgt;
                    slew_cnt_d = '0;
                end else if (btn_valid) begin
                    state_d    = BTN_STEP;
                    pwm_d      = btn_val;
                    upd_src    = SRC_BTN;
                    step_cnt_d = '0;
                end else if (auto_en) begin
                    state_d    = AUTO_STEP;
                    step_cnt_d = '0;
                end
            end

            HOST_SLEW: begin
                if (pwm_q == target_q) begin
                    state_d    = DONE;
                    host_ack_d = 1'b1;
                end else if (slew_tick) begin
                    pwm_d      = slew_val;
                    upd_src    = SRC_HOST;
                    slew_cnt_d = '0;
                end else begin
                    slew_cnt_d = slew_cnt_q + 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            BTN_STEP: begin
                if (host_req) begin
                    state_d    = HOST_SLEW;
                    target_d   = host_tgt;
                    slew_cnt_d = '0;
                end else if (!btn_valid) begin
                    state_d = IDLE;
                end else if (step_tick) begin
                    pwm_d      = btn_val;
                    upd_src    = SRC_BTN;
                    step_cnt_d = '0;
                end else begin
                    step_cnt_d = step_cnt_q + 1'b1;
                end
            end

            AUTO_STEP: begin
                if (host_req) begin
                    state_d    = HOST_SLEW;
                    target_d   = host_tgt;
                    slew_cnt_d = '0;
                end else if (btn_valid) begin
                    state_d    = BTN_STEP;
                    pwm_d      = btn_val;
                    upd_src    = SRC_BTN;
                    step_cnt_d = '0;
                end else if (!auto_en) begin
                    state_d = IDLE;
                end else if (step_tick) begin
                    pwm_d      = auto_val;
                    upd_src    = SRC_AUTO;
                    step_cnt_d = '0;
                end else begin
                    step_cnt_d = step_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // A saturated step writes the same value and must not strobe.
        changed_d    = (pwm_d != pwm_q);
        change_src_d = changed_d ? upd_src : change_src_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pwm_q        <= RESET_W;
            target_q     <= '0;
            step_cnt_q   <= '0;
            slew_cnt_q   <= '0;
            host_ack_q   <= 1'b0;
            changed_q    <= 1'b0;
            change_src_q <= SRC_NONE;
        end else begin
            state_q      <= state_d;
            pwm_q        <= pwm_d;
            target_q     <= target_d;
            step_cnt_q   <= step_cnt_d;
            slew_cnt_q   <= slew_cnt_d;
            host_ack_q   <= host_ack_d;
            changed_q    <= changed_d;
            change_src_q <= change_src_d;
        end
    end

    always_comb begin
        case (state_q)
            HOST_SLEW: active_src = SRC_HOST;
            BTN_STEP:  active_src = SRC_BTN;
            AUTO_STEP: active_src = SRC_AUTO;
            default:   active_src = SRC_NONE;
        endcase
    end

    assign pwm_on_time          = pwm_q;
    assign host_ack             = host_ack_q;
    assign pwm_on_value_changed = changed_q;
    assign change_src           = change_src_q;

endmodule

// File: tb/tb_contrast_level_arbiter.sv
// Directed bench for contrast_level_arbiter. Two instances share all inputs:
// dut_t ramps with wrap-around, dut_f saturates at the top. The register is
// one bit wider than needed so an out-of-range host value can be driven.
module tb_contrast_level_arbiter;
    localparam int W = 11;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         host_req = 1'b0;
    logic [W-1:0] host_value = '0;
    logic         btn_up = 1'b0;
    logic         btn_down = 1'b0;
    logic         auto_en = 1'b0;

    logic         ack_t, chg_t, ack_f, chg_f;
    logic [W-1:0] pwm_t, pwm_f;
    logic [1:0]   csrc_t, asrc_t, csrc_f, asrc_f;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    contrast_level_arbiter #(
        .CLOCK_FREQUENCY(100000), .PWM_REG_WIDTH(W), .PWM_CYCLE(1023),
        .STEP_VALUE(11), .STEP_TIME_MS(1), .SLEW_STEP(32),
        .SLEW_TICK_CYCLES(4), .AUTO_WRAP("TRUE"), .RESET_VALUE(0)
    ) dut_t (
        .clk(clk), .reset(reset), .host_req(host_req), .host_value(host_value),
        .host_ack(ack_t), .btn_up(btn_up), .btn_down(btn_down), .auto_en(auto_en),
        .pwm_on_time(pwm_t), .pwm_on_value_changed(chg_t),
        .change_src(csrc_t), .active_src(asrc_t)
    );

    contrast_level_arbiter #(
        .CLOCK_FREQUENCY(100000), .PWM_REG_WIDTH(W), .PWM_CYCLE(1023),
        .STEP_VALUE(11), .STEP_TIME_MS(1), .SLEW_STEP(32),
        .SLEW_TICK_CYCLES(4), .AUTO_WRAP("FALSE"), .RESET_VALUE(0)
    ) dut_f (
        .clk(clk), .reset(reset), .host_req(host_req), .host_value(host_value),
        .host_ack(ack_f), .btn_up(btn_up), .btn_down(btn_down), .auto_en(auto_en),
        .pwm_on_time(pwm_f), .pwm_on_value_changed(chg_f),
        .change_src(csrc_f), .active_src(asrc_f)
    );

    // Inputs change and outputs are sampled on the falling edge.
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; host_req = 1'b0; btn_up = 1'b0; btn_down = 1'b0; auto_en = 1'b0;
        cyc(2);
        reset = 1'b0;
    endtask

    // Complete host write; returns with the arbiter back in IDLE.
    task automatic host_write(input logic [W-1:0] v);
        bit got = 1'b0;
        host_value = v; host_req = 1'b1;
        for (int i = 0; i < 3000 && !got; i++) begin
            cyc(1);
            if (ack_t === 1'b1) got = 1'b1;
        end
        host_req = 1'b0;
        n_cmp++;
        if (!got) begin n_err++; $display("FAIL host_write_ack: no ack, required ack for value %0d", v); end
        cyc(1);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (pwm_t !== 11'd0) begin n_err++; $display("FAIL reset_pwm: got %0d required 0", pwm_t); end
        n_cmp++; if (ack_t !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %b required 0", ack_t); end
        n_cmp++; if (chg_t !== 1'b0) begin n_err++; $display("FAIL reset_strobe: got %b required 0", chg_t); end
        n_cmp++; if (csrc_t !== 2'd0) begin n_err++; $display("FAIL reset_change_src: got %0d required 0", csrc_t); end
        n_cmp++; if (asrc_t !== 2'd0) begin n_err++; $display("FAIL reset_active_src: got %0d required 0", asrc_t); end
    endtask

    task automatic test_host_slew();
        int strobes = 0;
        logic [W-1:0] exp_pwm;
        do_reset();
        host_value = 11'd100; host_req = 1'b1;
        for (int k = 0; k < 20; k++) begin
            cyc(1);
            if (k < 17) begin
                exp_pwm = (k < 4) ? 11'd0 : (k < 8) ? 11'd32 : (k < 12) ? 11'd64 : (k < 16) ? 11'd96 : 11'd100;
                n_cmp++;
                if (pwm_t !== exp_pwm) begin n_err++; $display("FAIL slew_pwm k=%0d: got %0d required %0d", k, pwm_t, exp_pwm); end
            end
            n_cmp++;
            if (ack_t !== (k == 17)) begin n_err++; $display("FAIL slew_ack k=%0d: got %b required %b", k, ack_t, (k == 17)); end
            if (chg_t === 1'b1) begin
                strobes++;
                n_cmp++;
                if (csrc_t !== 2'd1) begin n_err++; $display("FAIL slew_src k=%0d: got %0d required 1", k, csrc_t); end
            end
            if (k == 0) begin
                n_cmp++; if (asrc_t !== 2'd1) begin n_err++; $display("FAIL slew_active: got %0d required 1", asrc_t); end
            end
            // A fresh request is already pending during DONE; it must wait.
            if (k == 17) host_value = 11'd200;
            if (k == 18) begin
                n_cmp++; if (asrc_t !== 2'd0) begin n_err++; $display("FAIL done_ignores_req: active %0d required 0", asrc_t); end
            end
            if (k == 19) begin
                n_cmp++; if (asrc_t !== 2'd1) begin n_err++; $display("FAIL req_after_done: active %0d required 1", asrc_t); end
            end
        end
        host_req = 1'b0;
        n_cmp++; if (strobes != 4) begin n_err++; $display("FAIL slew_strobe_count: got %0d required 4", strobes); end
    endtask

    task automatic test_button();
        int strobes = 0;
        do_reset();
        btn_up = 1'b1;
        for (int k = 0; k < 250; k++) begin
            cyc(1);
            if (chg_t === 1'b1) strobes++;
            if (k == 0) begin
                n_cmp++; if (pwm_t !== 11'd11) begin n_err++; $display("FAIL btn_entry_pwm: got %0d required 11", pwm_t); end
                n_cmp++; if (csrc_t !== 2'd2) begin n_err++; $display("FAIL btn_src: got %0d required 2", csrc_t); end
                n_cmp++; if (asrc_t !== 2'd2) begin n_err++; $display("FAIL btn_active: got %0d required 2", asrc_t); end
            end
            if (k == 99) begin
                n_cmp++; if (pwm_t !== 11'd11) begin n_err++; $display("FAIL btn_pre_tick: got %0d required 11", pwm_t); end
            end
            if (k == 100) begin
                n_cmp++; if (pwm_t !== 11'd22) begin n_err++; $display("FAIL btn_tick1: got %0d required 22", pwm_t); end
            end
            if (k == 200) begin
                n_cmp++; if (pwm_t !== 11'd33) begin n_err++; $display("FAIL btn_tick2: got %0d required 33", pwm_t); end
            end
        end
        btn_up = 1'b0;
        cyc(1);
        n_cmp++; if (asrc_t !== 2'd0) begin n_err++; $display("FAIL btn_release: active %0d required 0", asrc_t); end
        n_cmp++; if (pwm_t !== 11'd33) begin n_err++; $display("FAIL btn_release_pwm: got %0d required 33", pwm_t); end
        n_cmp++; if (strobes != 3) begin n_err++; $display("FAIL btn_strobe_count: got %0d required 3", strobes); end
    endtask

    task automatic test_saturation();
        int strobes = 0;
        do_reset();
        host_write(11'd1020);
        btn_up = 1'b1;
        cyc(1);
        n_cmp++; if (pwm_t !== 11'd1023) begin n_err++; $display("FAIL up_clamp: got %0d required 1023", pwm_t); end
        n_cmp++; if (chg_t !== 1'b1) begin n_err++; $display("FAIL up_clamp_strobe: got %b required 1", chg_t); end
        for (int k = 0; k < 150; k++) begin
            cyc(1);
            if (chg_t === 1'b1) strobes++;
        end
        n_cmp++; if (strobes != 0) begin n_err++; $display("FAIL up_saturated_strobes: got %0d required 0", strobes); end
        n_cmp++; if (pwm_t !== 11'd1023) begin n_err++; $display("FAIL up_saturated_pwm: got %0d required 1023", pwm_t); end
        btn_up = 1'b0;
        cyc(1);

        host_write(11'd5);
        btn_down = 1'b1;
        cyc(1);
        n_cmp++; if (pwm_t !== 11'd0) begin n_err++; $display("FAIL down_clamp: got %0d required 0", pwm_t); end
        btn_down = 1'b0;
        cyc(1);

        host_write(11'd50);
        btn_up = 1'b1; btn_down = 1'b1;
        strobes = 0;
        for (int k = 0; k < 150; k++) begin
            cyc(1);
            if (chg_t === 1'b1) strobes++;
        end
        n_cmp++; if (strobes != 0) begin n_err++; $display("FAIL both_btn_strobes: got %0d required 0", strobes); end
        n_cmp++; if (pwm_t !== 11'd50) begin n_err++; $display("FAIL both_btn_pwm: got %0d required 50", pwm_t); end
        n_cmp++; if (asrc_t !== 2'd0) begin n_err++; $display("FAIL both_btn_active: got %0d required 0", asrc_t); end
        btn_up = 1'b0; btn_down = 1'b0;
        cyc(1);
    endtask

    task automatic test_auto();
        int st_t = 0;
        int st_f = 0;
        do_reset();
        host_write(11'd1012);
        auto_en = 1'b1;
        for (int k = 0; k <= 200; k++) begin
            cyc(1);
            if (chg_t === 1'b1) st_t++;
            if (chg_f === 1'b1) st_f++;
            if (k == 0) begin
                n_cmp++; if (asrc_t !== 2'd3) begin n_err++; $display("FAIL auto_active: got %0d required 3", asrc_t); end
                n_cmp++; if (pwm_t !== 11'd1012) begin n_err++; $display("FAIL auto_no_immediate: got %0d required 1012", pwm_t); end
            end
            if (k == 100) begin
                n_cmp++; if (pwm_t !== 11'd1023) begin n_err++; $display("FAIL auto_wrap_tick1: got %0d required 1023", pwm_t); end
                n_cmp++; if (pwm_f !== 11'd1023) begin n_err++; $display("FAIL auto_sat_tick1: got %0d required 1023", pwm_f); end
            end
            if (k == 200) begin
                n_cmp++; if (pwm_t !== 11'd0) begin n_err++; $display("FAIL auto_wrap_tick2: got %0d required 0", pwm_t); end
                n_cmp++; if (pwm_f !== 11'd1023) begin n_err++; $display("FAIL auto_sat_tick2: got %0d required 1023", pwm_f); end
                n_cmp++; if (csrc_t !== 2'd3) begin n_err++; $display("FAIL auto_src_wrap: got %0d required 3", csrc_t); end
                n_cmp++; if (csrc_f !== 2'd3) begin n_err++; $display("FAIL auto_src_sat: got %0d required 3", csrc_f); end
            end
        end
        n_cmp++; if (st_t != 2) begin n_err++; $display("FAIL auto_wrap_strobes: got %0d required 2", st_t); end
        n_cmp++; if (st_f != 1) begin n_err++; $display("FAIL auto_sat_strobes: got %0d required 1", st_f); end
        auto_en = 1'b0;
        cyc(1);
        n_cmp++; if (asrc_t !== 2'd0) begin n_err++; $display("FAIL auto_disable: active %0d required 0", asrc_t); end
    endtask

    task automatic test_priority();
        bit got;
        do_reset();
        host_value = 11'd40; host_req = 1'b1; btn_up = 1'b1;
        for (int k = 0; k < 12; k++) begin
            cyc(1);
            if (k == 0) begin
                n_cmp++; if (asrc_t !== 2'd1) begin n_err++; $display("FAIL prio_host_wins: active %0d required 1", asrc_t); end
                n_cmp++; if (pwm_t !== 11'd0) begin n_err++; $display("FAIL prio_no_btn_step: got %0d required 0", pwm_t); end
            end
            if (k == 8) begin
                n_cmp++; if (pwm_t !== 11'd40) begin n_err++; $display("FAIL prio_slew_end: got %0d required 40", pwm_t); end
            end
            if (k == 9) begin
                n_cmp++; if (ack_t !== 1'b1) begin n_err++; $display("FAIL prio_ack: got %b required 1", ack_t); end
                host_req = 1'b0;
            end
            if (k == 10) begin
                n_cmp++; if (asrc_t !== 2'd0 || pwm_t !== 11'd40) begin n_err++; $display("FAIL prio_done_idle: active %0d pwm %0d required 0/40", asrc_t, pwm_t); end
            end
            if (k == 11) begin
                n_cmp++; if (asrc_t !== 2'd2 || pwm_t !== 11'd51 || csrc_t !== 2'd2) begin n_err++; $display("FAIL prio_btn_after: active %0d pwm %0d src %0d required 2/51/2", asrc_t, pwm_t, csrc_t); end
            end
        end
        btn_up = 1'b0;
        cyc(1);

        do_reset();
        auto_en = 1'b1;
        cyc(20);
        n_cmp++; if (asrc_t !== 2'd3) begin n_err++; $display("FAIL preempt_auto_pre: active %0d required 3", asrc_t); end
        host_value = 11'd8; host_req = 1'b1;
        cyc(1);
        n_cmp++; if (asrc_t !== 2'd1) begin n_err++; $display("FAIL preempt_auto: active %0d required 1", asrc_t); end
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            cyc(1);
            if (ack_t === 1'b1) got = 1'b1;
        end
        n_cmp++; if (!got || pwm_t !== 11'd8) begin n_err++; $display("FAIL preempt_result: ack %b pwm %0d required 1/8", got, pwm_t); end
        host_req = 1'b0; auto_en = 1'b0;
        cyc(1);

        do_reset();
        host_value = 11'd2000; host_req = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 1000 && !got; i++) begin
            cyc(1);
            if (ack_t === 1'b1) got = 1'b1;
        end
        n_cmp++; if (!got || pwm_t !== 11'd1023) begin n_err++; $display("FAIL host_clamp: ack %b pwm %0d required 1/1023", got, pwm_t); end
        host_req = 1'b0;
        cyc(1);
    endtask

    task automatic test_reset_mid_slew();
        int acks = 0;
        do_reset();
        host_value = 11'd500; host_req = 1'b1;
        cyc(9);
        n_cmp++; if (pwm_t !== 11'd64) begin n_err++; $display("FAIL midslew_pre: got %0d required 64", pwm_t); end
        reset = 1'b1;
        cyc(1);
        n_cmp++; if (pwm_t !== 11'd0) begin n_err++; $display("FAIL midslew_pwm: got %0d required 0", pwm_t); end
        n_cmp++; if (asrc_t !== 2'd0) begin n_err++; $display("FAIL midslew_active: got %0d required 0", asrc_t); end
        n_cmp++; if (ack_t !== 1'b0 || chg_t !== 1'b0 || csrc_t !== 2'd0) begin n_err++; $display("FAIL midslew_flags: ack %b strobe %b src %0d required 0/0/0", ack_t, chg_t, csrc_t); end
        host_req = 1'b0; reset = 1'b0;
        for (int k = 0; k < 30; k++) begin
            cyc(1);
            if (ack_t === 1'b1) acks++;
        end
        n_cmp++; if (acks != 0 || pwm_t !== 11'd0) begin n_err++; $display("FAIL midslew_abandon: acks %0d pwm %0d required 0/0", acks, pwm_t); end
    endtask

    initial begin
        test_reset();
        test_host_slew();
        test_button();
        test_saturation();
        test_auto();
        test_priority();
        test_reset_mid_slew();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
